hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves branch flushes, load-use bubbles and
// multi-cycle mult/div stalls, and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        md_start,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_bubble,
  output logic        stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_count,
  output logic        protocol_err
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  // The accepting cycle counts as the first EX cycle, and the done cycle as the last.
  localparam logic [7:0] MD_RELOAD = 8'(MD_CYCLES - 2);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q;
  logic        protocol_err_q, protocol_err_d;

  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    idex_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_bubble   = 1'b0;
    stall          = 1'b0;
    md_busy        = 1'b0;
    md_done        = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    protocol_err_d = protocol_err_q;

    if (rst) begin
      pc_write       = 1'b0;
      ifid_write     = 1'b0;
      idex_write     = 1'b0;
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      state_d        = RUN;
      cnt_d          = 8'd0;
      protocol_err_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            stall      = 1'b1;
            if (md_start) protocol_err_d = 1'b1;
          end else if (md_start) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            md_busy      = 1'b1;
            stall        = 1'b1;
            state_d      = MD_WAIT;
            cnt_d        = MD_RELOAD;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall      = 1'b1;
          end
        end
        MD_WAIT: begin
          // All hazard inputs are ignored until the mult/div completes.
          if (cnt_q != 8'd0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            md_busy      = 1'b1;
            stall        = 1'b1;
            cnt_d        = cnt_q - 8'd1;
          end else begin
            md_done = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= 8'd0;
      protocol_err_q <= 1'b0;
      stall_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      protocol_err_q <= protocol_err_d;
      if (stall && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  // Masked so the reported values read zero for the whole reset period.
  assign stall_count  = rst ? 16'd0 : stall_count_q;
  assign protocol_err = protocol_err_q & ~rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl (MD_CYCLES=4) plus a long
// stall-counter saturation sequence.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_use, branch_taken, md_start;
  logic        pc_write, ifid_write, idex_write, ifid_flush, idex_flush;
  logic        exmem_bubble, stall, md_busy, md_done, protocol_err;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
    .md_start(md_start), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble), .stall(stall), .md_busy(md_busy),
    .md_done(md_done), .stall_count(stall_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Control bits: {pc_w, ifid_w, idex_w, ifid_f, idex_f, bubble, stall, busy, done, perr}
  localparam logic [9:0] C_RST  = 10'b0001100000;
  localparam logic [9:0] C_IDLE = 10'b1110000000;
  localparam logic [9:0] C_LU   = 10'b0010101000;
  localparam logic [9:0] C_BR   = 10'b1111101000;
  localparam logic [9:0] C_MD   = 10'b0000011100;
  localparam logic [9:0] C_DONE = 10'b1110000010;
  localparam logic [9:0] PERR   = 10'b0000000001;

  typedef struct {
    logic        rst, lu, br, md;
    logic [9:0]  ctl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  task automatic add(input logic r, input logic lu, input logic br, input logic md,
                     input logic [9:0] ctl, input logic [15:0] cnt);
    vecs[nv] = '{r, lu, br, md, ctl, cnt};
    nv++;
  endtask

  function automatic logic [9:0] ctl_now();
    return {pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
            exmem_bubble, stall, md_busy, md_done, protocol_err};
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; load_use = 1'b0; branch_taken = 1'b0; md_start = 1'b0;

    // reset, with inputs ignored
    add(1,0,0,0, C_RST, 0);
    add(1,1,1,1, C_RST, 0);
    add(0,0,0,0, C_IDLE, 0);
    // two load-use cycles
    add(0,1,0,0, C_LU, 0);
    add(0,1,0,0, C_LU, 1);
    add(0,0,0,0, C_IDLE, 2);
    // branch beats load_use, no protocol error
    add(0,1,1,0, C_BR, 2);
    // mult/div at T, inputs ignored while waiting, done at T+3
    add(0,0,0,1, C_MD, 3);
    add(0,1,1,0, C_MD, 4);
    add(0,0,0,1, C_MD, 5);
    add(0,0,0,0, C_DONE, 6);
    add(0,0,0,0, C_IDLE, 6);
    // branch + md_start: flush wins, error becomes sticky
    add(0,0,1,1, C_BR, 6);
    add(0,0,0,0, C_IDLE | PERR, 7);
    add(0,1,0,0, C_LU | PERR, 7);
    // reset clears error and counter
    add(1,0,0,0, C_RST, 0);
    add(0,0,0,0, C_IDLE, 0);
    // reset at T+1 of an md sequence aborts it
    add(0,0,0,1, C_MD, 0);
    add(1,0,0,0, C_RST, 0);
    add(0,0,0,0, C_IDLE, 0);
    add(0,0,0,0, C_IDLE, 0);
    // md_start in the done cycle is ignored; next one accepted afterwards
    add(0,0,0,1, C_MD, 0);
    add(0,0,0,0, C_MD, 1);
    add(0,0,0,0, C_MD, 2);
    add(0,0,0,1, C_DONE, 3);
    add(0,0,0,0, C_IDLE, 3);
    add(0,0,0,1, C_MD, 3);
    add(0,0,0,0, C_MD, 4);

    for (int i = 0; i < nv; i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; load_use = vecs[i].lu;
      branch_taken = vecs[i].br; md_start = vecs[i].md;
      @(negedge clk);
      $display("vec %0d: rst=%b lu=%b br=%b md=%b ctl=%b cnt=%0d", i,
               vecs[i].rst, vecs[i].lu, vecs[i].br, vecs[i].md, ctl_now(), stall_count);
      check10($sformatf("vec%0d_ctl", i), ctl_now(), vecs[i].ctl);
      check16($sformatf("vec%0d_cnt", i), stall_count, vecs[i].cnt);
    end

    // Saturation: continuous load_use after a reset cycle.
    @(posedge clk); #1;
    rst = 1'b1; load_use = 1'b0; branch_taken = 1'b0; md_start = 1'b0;
    for (int i = 0; i <= 70000; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; load_use = 1'b1;
      @(negedge clk);
      if (i == 0 || i == 65534 || i == 65535 || i == 70000) begin
        check16($sformatf("sat_cnt_%0d", i), stall_count, (i > 65535) ? 16'hFFFF : 16'(i));
        $display("sat %0d: stall=%b cnt=%h", i, stall, stall_count);
      end
    end
    check10("sat_ctl", ctl_now(), C_LU);

    @(posedge clk); #1;
    load_use = 1'b0;
    @(negedge clk);
    check16("sat_hold", stall_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
